// File: rtl/handshake_muli_sat_pipe_pkg.sv
// Shared definitions for the softclip handshake blocks: Q-format constants,
// saturation bounds and the join-ready rule used by every two-input join.
package handshake_muli_sat_pipe_pkg;

    localparam int          DATA_WIDTH = 24;
    localparam int          FRAC_BITS  = 22;
    localparam logic [23:0] SAT_MAX    = 24'h7FFFFF;
    localparam logic [23:0] SAT_MIN    = 24'h800000;

    // A join input may be taken only when its partner is valid and the join can advance.
    function automatic logic join_ready(input logic other_valid, input logic adv, input logic rst);
        return other_valid & adv & ~rst;
    endfunction

endpackage

// File: rtl/handshake_pipe_stage.sv
// One elastic pipeline slot: valid bit plus data, loaded whenever the slot may
// advance. Data is only overwritten by valid input so a bubble never disturbs it.
module handshake_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next-state: take upstream contents on advance, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/handshake_muli_sat_pipe.sv
// Elastic 3-stage signed fixed-point multiplier: operand join, full product,
// then arithmetic rescale with saturation. Result comes straight from registers.
module handshake_muli_sat_pipe #(
    parameter int DATA_WIDTH = handshake_muli_sat_pipe_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = handshake_muli_sat_pipe_pkg::FRAC_BITS,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic                  lhs_valid,
    output logic                  lhs_ready,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  rhs_valid,
    output logic                  rhs_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    import handshake_muli_sat_pipe_pkg::*;

    localparam int                  PW     = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT_HI = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_LO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (LATENCY != 3) begin : g_bad_latency
        $error("handshake_muli_sat_pipe supports LATENCY == 3 only");
    end

    logic                  v1_s;
    logic                  v2_s;
    logic                  v3_s;
    logic                  s0_adv_s;
    logic                  s1_adv_s;
    logic                  s2_adv_s;
    logic                  s3_adv_s;
    logic                  join_fire_s;
    logic [PW-1:0]         s1_data_s;
    logic [PW-1:0]         s2_data_s;
    logic signed [PW-1:0]  prod_s;
    logic signed [PW-1:0]  shifted_s;
    logic [DATA_WIDTH-1:0] sat_s;

    // Each stage may move when it is empty or its successor moves, so bubbles collapse.
    assign s3_adv_s    = ~v3_s | result_ready;
    assign s2_adv_s    = ~v2_s | s3_adv_s;
    assign s1_adv_s    = ~v1_s | s2_adv_s;
    assign s0_adv_s    = s1_adv_s;
    assign join_fire_s = lhs_valid & rhs_valid & s0_adv_s & ~rst;
    assign lhs_ready   = join_ready(rhs_valid, s0_adv_s, rst);
    assign rhs_ready   = join_ready(lhs_valid, s0_adv_s, rst);

    handshake_pipe_stage #(.W(PW)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (s1_adv_s),
        .valid_i (join_fire_s),
        .data_i  ({lhs, rhs}),
        .valid_o (v1_s),
        .data_o  (s1_data_s)
    );

    assign prod_s = PW'($signed(s1_data_s[PW-1:DATA_WIDTH])) * PW'($signed(s1_data_s[DATA_WIDTH-1:0]));

    handshake_pipe_stage #(.W(PW)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (s2_adv_s),
        .valid_i (v1_s),
        .data_i  (prod_s),
        .valid_o (v2_s),
        .data_o  (s2_data_s)
    );

    assign shifted_s = $signed(s2_data_s) >>> FRAC_BITS;

    // Clamp when the bits above the result sign are not a pure sign extension.
    always_comb begin
        sat_s = shifted_s[DATA_WIDTH-1:0];
        if ((&shifted_s[PW-1:DATA_WIDTH-1]) | ~(|shifted_s[PW-1:DATA_WIDTH-1])) begin
            sat_s = shifted_s[DATA_WIDTH-1:0];
        end else if (shifted_s[PW-1]) begin
            sat_s = SAT_LO;
        end else begin
            sat_s = SAT_HI;
        end
    end

    handshake_pipe_stage #(.W(DATA_WIDTH)) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (s3_adv_s),
        .valid_i (v2_s),
        .data_i  (sat_s),
        .valid_o (v3_s),
        .data_o  (result)
    );

    assign result_valid = v3_s;

endmodule

// File: tb/tb_handshake_muli_sat_pipe.sv
// Directed table + streaming scoreboard bench for handshake_muli_sat_pipe.
module tb_handshake_muli_sat_pipe;

    import handshake_muli_sat_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] lhs;
    logic        lhs_valid;
    logic        lhs_ready;
    logic [23:0] rhs;
    logic        rhs_valid;
    logic        rhs_ready;
    logic [23:0] result;
    logic        result_valid;
    logic        result_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    handshake_muli_sat_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .lhs          (lhs),
        .lhs_valid    (lhs_valid),
        .lhs_ready    (lhs_ready),
        .rhs          (rhs),
        .rhs_valid    (rhs_valid),
        .rhs_ready    (rhs_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] e;
        string       nm;
    } vec_t;

    vec_t vecs[10];

    logic [23:0] exp_q[$];
    int          recv = 0;
    bit          sb_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_res;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] a, input logic [23:0] b);
        longint p;
        longint s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = p >>> FRAC_BITS;
        if (s > 64'sd8388607) return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    function automatic logic [23:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if (r[31]) return r[23:0];
        return {{3{r[20]}}, r[20:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push model result on fire, compare on accept, watch stall stability.
    always @(negedge clk) begin
        if (!sb_en || rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", result_valid, 1);
                check("stall_result_held", result, prev_res);
            end
            if (lhs_valid && lhs_ready) exp_q.push_back(model(lhs, rhs));
            if (result_valid && result_ready) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("stream_data", result, exp_q.pop_front());
                recv++;
            end
            prev_stall = result_valid && !result_ready;
            prev_res   = result;
        end
    end

    task automatic single(input logic [23:0] a, input logic [23:0] b, input logic [23:0] e, input string nm);
        int n;
        lhs = a; rhs = b; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
        #1;
        check({nm, "_lhs_ready"}, lhs_ready, 1);
        check({nm, "_rhs_ready"}, rhs_ready, 1);
        tick();
        lhs_valid = 1'b0; rhs_valid = 1'b0;
        n = 1;
        while (!result_valid && n < 8) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, n, 3);
        check({nm, "_data"}, result, e);
        tick();
        check({nm, "_drain"}, result_valid, 0);
    endtask

    // mode 0: ready low for cycles 4..8; mode 1: random valid/ready on every channel.
    task automatic stream(input int n, input int mode, input int limit);
        int          idx = 0;
        int          c = 0;
        logic        fired;
        logic [23:0] a;
        logic [23:0] b;
        recv = 0;
        a = rand_op(); b = rand_op();
        while ((idx < n || recv < n) && c < limit) begin
            lhs = a; rhs = b;
            if (mode == 0) begin
                lhs_valid    = (idx < n);
                rhs_valid    = (idx < n);
                result_ready = !(c >= 4 && c <= 8);
            end else begin
                lhs_valid    = (idx < n) && ($urandom_range(0, 3) != 0);
                rhs_valid    = (idx < n) && ($urandom_range(0, 3) != 0);
                result_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (mode == 0 && c == 8) begin
                check("bp_lhs_ready_low", lhs_ready, 0);
                check("bp_rhs_ready_low", rhs_ready, 0);
                check("bp_result_valid", result_valid, 1);
            end
            @(negedge clk);
            fired = lhs_valid && lhs_ready;
            tick();
            c++;
            if (fired) begin
                idx++;
                a = rand_op(); b = rand_op();
            end
        end
        lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
        check("stream_count", recv, n);
        check("stream_leftover", exp_q.size(), 0);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{24'h400000, 24'h581679, 24'h581679, "unit"};
        vecs[1] = '{24'hC00000, 24'h581679, 24'hA7E987, "neg"};
        vecs[2] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, "sat_pos"};
        vecs[3] = '{24'h800000, 24'h7FFFFF, 24'h800000, "sat_neg"};
        vecs[4] = '{24'h800000, 24'h800000, 24'h7FFFFF, "sat_minmin"};
        vecs[5] = '{24'h200000, 24'h200000, 24'h100000, "half_sq"};
        vecs[6] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, "trunc_neg"};
        vecs[7] = '{24'h000001, 24'h000001, 24'h000000, "trunc_pos"};
        vecs[8] = '{24'h800000, 24'h200000, 24'hC00000, "neg2_half"};
        vecs[9] = '{24'h000000, 24'h581679, 24'h000000, "zero"};

        rst = 1'b1; lhs = 24'h123456; rhs = 24'h654321;
        lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
        tick();
        check("rst_lhs_ready", lhs_ready, 0);
        check("rst_rhs_ready", rhs_ready, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        tick();
        rst = 1'b0; lhs_valid = 1'b0; rhs_valid = 1'b0;
        tick();

        // lhs waits alone: no fire while rhs is absent.
        lhs_valid = 1'b1; rhs_valid = 1'b0;
        #1;
        check("join_rhs_ready", rhs_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (lhs_ready) seen = 1'b1;
            tick();
        end
        check("join_lhs_ready_low", seen, 0);
        lhs_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (result_valid) seen = 1'b1;
            tick();
        end
        check("join_no_fire", seen, 0);

        for (int i = 0; i < 10; i++) single(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].nm);

        sb_en = 1'b1;
        stream(6, 0, 200);
        sb_en = 1'b0;
        tick();

        // Reset with three items in flight.
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lhs = vecs[i].a; rhs = vecs[i].b; lhs_valid = 1'b1; rhs_valid = 1'b1;
            if (i == 2) result_ready = 1'b0;
            tick();
        end
        lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b0;
        check("pre_reset_valid", result_valid, 1);
        rst = 1'b1;
        tick();
        check("midrst_result_valid", result_valid, 0);
        check("midrst_result", result, 0);
        rst = 1'b0; result_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (result_valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_stale", seen, 0);
        single(24'h400000, 24'h581679, 24'h581679, "post_rst");

        sb_en = 1'b1;
        stream(3000, 1, 40000);
        sb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
